instr_seq: RTL and testbench

INSTR_SEQ -- requirements
Module: instr_seq

---
 rtl/instr_seq.sv | 115 +++++++++++
 tb/tb_instr_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_seq.sv
// Instruction sequencer: fetches words from instruction memory, issues them to the decoder, follows redirects.
// Fetch-to-issue latency is one cycle after imem_ready; a stalled issue holds instr/pc until stall drops.
module instr_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    // Count of completed empty FETCH cycles at which the current cycle is the TIMEOUT-th one.
    localparam logic [7:0]  LP_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_boot;
    logic [7:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_req;
    logic        r_fault;

    logic [31:0] w_next_pc;
    logic        w_misalign;

    assign w_next_pc  = redirect ? redirect_pc : r_pc + 32'd4;
    assign w_misalign = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_boot  <= 1'b0;
            r_cnt   <= 8'd0;
            r_pc    <= RESET_PC;
            r_instr <= NOP;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                // The first edge after release only arms; IDLE then lasts one full cycle.
                IDLE: begin
                    if (r_boot) begin
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_boot <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ready) begin
                        r_instr <= imem_data;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= ISSUE;
                    end else if (r_cnt == LP_LAST) begin
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= FAULT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_next_pc;
                        if (w_misalign) begin
                            r_fault <= 1'b1;
                            r_state <= FAULT;
                        end else begin
                            r_req   <= 1'b1;
                            r_cnt   <= 8'd0;
                            r_state <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign fault       = r_fault;

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: instance A (TIMEOUT=3, RESET_PC=0) and instance B (RESET_PC=0xFFFF_FFFC) share stimulus.
module tb_instr_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        a_req, a_valid, a_fault;
    logic [31:0] a_addr, a_instr, a_pc;
    logic        b_req, b_valid, b_fault;
    logic [31:0] b_addr, b_instr, b_pc;

    int n_checks = 0;
    int n_fail   = 0;

    instr_seq #(.RESET_PC(32'h0000_0000), .TIMEOUT(3)) dut_a (
        .clk(clk), .reset(reset), .imem_req(a_req), .imem_addr(a_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .instr(a_instr),
        .instr_valid(a_valid), .pc(a_pc), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .fault(a_fault)
    );

    instr_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_ready(imem_ready), .imem_data(imem_data), .instr(b_instr),
        .instr_valid(b_valid), .pc(b_pc), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .fault(b_fault)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset both instances; returns at the negedge after the first fetch request is raised.
    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick; tick;
        reset = 1'b0;
        tick; tick;
    endtask

    // Expects A in its first FETCH cycle; returns ready on the delay-th FETCH cycle and checks the issue.
    task automatic issue_word(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
        n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req @%h: got %b want 1", exp_addr, a_req); end
        n_checks++; if (a_addr !== exp_addr) begin n_fail++; $display("FAIL fetch_addr: got %h want %h", a_addr, exp_addr); end
        repeat (delay - 1) tick;
        imem_ready = 1'b1; imem_data = word;
        tick;
        imem_ready = 1'b0;
        n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL issue_valid @%h: got %b want 1", exp_addr, a_valid); end
        n_checks++; if (a_instr !== word) begin n_fail++; $display("FAIL issue_instr @%h: got %h want %h", exp_addr, a_instr, word); end
        n_checks++; if (a_pc !== exp_addr) begin n_fail++; $display("FAIL issue_pc: got %h want %h", a_pc, exp_addr); end
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL issue_req @%h: got %b want 0", exp_addr, a_req); end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (a_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", a_pc); end
        n_checks++; if (a_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", a_instr); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", a_req); end
        n_checks++; if (a_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", a_fault); end
        n_checks++; if (b_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc_b: got %h want fffffffc", b_pc); end
        reset = 1'b0;
        tick;
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", a_req); end
        tick;
        n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", a_req); end
    endtask

    task automatic test_basic;
        issue_word(32'h0, 32'h0010_0093, 2);
        tick;
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse: got %b want 0", a_valid); end
        issue_word(32'h4, 32'h0020_0113, 2);
        tick;
        issue_word(32'h8, 32'h0030_0193, 2);
        tick;
    endtask

    task automatic test_stall;
        issue_word(32'hC, 32'h0050_0093, 2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, a_valid); end
            n_checks++; if (a_instr !== 32'h0050_0093) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want 00500093", i, a_instr); end
            n_checks++; if (a_pc !== 32'hC) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want c", i, a_pc); end
            n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b want 0", i, a_req); end
        end
        stall = 1'b0;
        tick;
    endtask

    task automatic test_redirect;
        issue_word(32'h10, 32'h0000_006F, 2);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        tick;
        n_checks++; if (a_pc !== 32'h10) begin n_fail++; $display("FAIL redirect_stalled_pc: got %h want 10", a_pc); end
        n_checks++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL redirect_stalled_valid: got %b want 1", a_valid); end
        stall = 1'b0; redirect_pc = 32'h200;
        tick;
        redirect = 1'b0;
    endtask

    task automatic test_timeout;
        issue_word(32'h200, 32'h00A0_0513, 3);
        n_checks++; if (a_fault !== 1'b0) begin n_fail++; $display("FAIL ready_at_limit_fault: got %b want 0", a_fault); end
        tick;
        tick; tick;
        n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL timeout_wait_req: got %b want 1", a_req); end
        n_checks++; if (a_fault !== 1'b0) begin n_fail++; $display("FAIL timeout_early_fault: got %b want 0", a_fault); end
        tick;
        n_checks++; if (a_fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b want 1", a_fault); end
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL timeout_req: got %b want 0", a_req); end
        n_checks++; if (a_pc !== 32'h204) begin n_fail++; $display("FAIL timeout_pc: got %h want 204", a_pc); end
        imem_ready = 1'b1; imem_data = 32'h1234_5678; redirect = 1'b1; redirect_pc = 32'h40;
        tick; tick;
        imem_ready = 1'b0; redirect = 1'b0;
        n_checks++; if (a_fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b want 1", a_fault); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL fault_valid: got %b want 0", a_valid); end
        n_checks++; if (a_pc !== 32'h204) begin n_fail++; $display("FAIL fault_pc_hold: got %h want 204", a_pc); end
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL fault_req_hold: got %b want 0", a_req); end
    endtask

    task automatic test_misaligned;
        do_reset;
        issue_word(32'h0, 32'h0040_006F, 2);
        redirect = 1'b1; redirect_pc = 32'h202;
        tick;
        redirect = 1'b0;
        n_checks++; if (a_fault !== 1'b1) begin n_fail++; $display("FAIL misalign_fault: got %b want 1", a_fault); end
        n_checks++; if (a_pc !== 32'h202) begin n_fail++; $display("FAIL misalign_pc: got %h want 202", a_pc); end
        n_checks++; if (a_addr !== 32'h202) begin n_fail++; $display("FAIL misalign_addr: got %h want 202", a_addr); end
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL misalign_req: got %b want 0", a_req); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_valid: got %b want 0", a_valid); end
    endtask

    task automatic test_wrap;
        do_reset;
        n_checks++; if (b_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first_addr: got %h want fffffffc", b_addr); end
        n_checks++; if (b_req !== 1'b1) begin n_fail++; $display("FAIL wrap_first_req: got %b want 1", b_req); end
        imem_ready = 1'b1; imem_data = 32'h0010_8093;
        tick;
        imem_ready = 1'b0;
        n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b want 1", b_valid); end
        n_checks++; if (b_instr !== 32'h0010_8093) begin n_fail++; $display("FAIL wrap_instr: got %h want 00108093", b_instr); end
        tick;
        n_checks++; if (b_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_second_addr: got %h want 0", b_addr); end
        n_checks++; if (b_req !== 1'b1) begin n_fail++; $display("FAIL wrap_second_req: got %b want 1", b_req); end
    endtask

    task automatic test_async_reset;
        n_checks++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req: got %b want 1", a_req); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL async_req: got %b want 0", a_req); end
        n_checks++; if (a_pc !== 32'h0) begin n_fail++; $display("FAIL async_pc: got %h want 0", a_pc); end
        n_checks++; if (a_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL async_instr: got %h want 00000013", a_instr); end
        n_checks++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", a_valid); end
        n_checks++; if (a_fault !== 1'b0) begin n_fail++; $display("FAIL async_fault: got %b want 0", a_fault); end
        n_checks++; if (b_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL async_pc_b: got %h want fffffffc", b_pc); end
        n_checks++; if (b_req !== 1'b0) begin n_fail++; $display("FAIL async_req_b: got %b want 0", b_req); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        n_checks++; if (a_addr !== 32'h10) begin n_fail++; $display("FAIL post_stall_addr: got %h want 10", a_addr); end
        test_redirect;
        n_checks++; if (a_addr !== 32'h200) begin n_fail++; $display("FAIL redirect_addr: got %h want 200", a_addr); end
        test_timeout;
        test_misaligned;
        test_wrap;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
